if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 97 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with PC, IF/ID register and a one-word
// hold buffer that catches a returned word while the pipeline is stalled.
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        noop_o
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;

    // Reset gates the request directly so it drops without waiting for an edge.
    assign imem_req_o   = (state == FETCH) && !rst_i;
    assign imem_addr_o  = pc;
    assign ifid_pc_o    = ifid_pc;
    assign ifid_instr_o = ifid_instr;
    assign ifid_valid_o = ifid_valid;
    assign noop_o       = !ifid_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= FETCH;
            pc         <= RESET_PC & ALIGN_MASK;
            hold_buf   <= NOP_INSTR;
            ifid_pc    <= 32'h0000_0000;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush_i) begin
                        pc         <= branch_target_i & ALIGN_MASK;
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end else if (stall_i) begin
                        if (imem_ready_i) begin
                            hold_buf <= imem_rdata_i;
                            state    <= HOLD;
                        end
                    end else if (imem_ready_i) begin
                        ifid_pc    <= pc;
                        ifid_instr <= imem_rdata_i;
                        ifid_valid <= 1'b1;
                        pc         <= pc + 32'd4;
                    end else begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush_i) begin
                        hold_buf   <= NOP_INSTR;
                        pc         <= branch_target_i & ALIGN_MASK;
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        state      <= FETCH;
                    end else if (!stall_i) begin
                        ifid_pc    <= pc;
                        ifid_instr <= hold_buf;
                        ifid_valid <= 1'b1;
                        hold_buf   <= NOP_INSTR;
                        pc         <= pc + 32'd4;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire
